// File: rtl/alu_pkg.sv
// Shared types for the ALU issue sequencer: opcodes, destination kinds, FSM states, queued-op record.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU
  } ALU_OP_CODE;

  typedef enum logic [1:0] {DEST_REG, DEST_MEM, DEST_PC} dest_kind_e;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} alu_seq_state_e;

  typedef struct packed {
    ALU_OP_CODE  op;
    logic [31:0] a;
    logic [31:0] b;
    dest_kind_e  dest;
    logic [4:0]  reg_addr;
    logic [31:0] mem_addr;
  } alu_issue_t;

endpackage

// File: rtl/alu_seq_fifo.sv
// Small power-of-2 FIFO of decoded ops; clear drops every entry and any same-cycle push.
module alu_seq_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  alu_issue_t             wdata,
  output alu_issue_t             head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  alu_issue_t     mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic           do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Issue controller between decode and the ALU: one op in flight, flush on taken jump, done timeout.
// Optional ALU_SEQ_PERF_EN adds issued-op and stall-cycle counters.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  ALU_OP_CODE  issue_op_code,
  input  logic [31:0] issue_A,
  input  logic [31:0] issue_B,
  input  dest_kind_e  issue_dest,
  input  logic [4:0]  issue_reg_addr,
  input  logic [31:0] issue_mem_addr,
  output ALU_OP_CODE  alu_op_code,
  output logic [31:0] alu_input_A,
  output logic [31:0] alu_input_B,
  output logic        alu_reg_out,
  output logic [4:0]  alu_reg_addr,
  output logic        alu_mem_out,
  output logic [31:0] alu_mem_addr,
  output logic        alu_pc_jump,
  output logic        alu_inputs_valid,
  input  logic        alu_done,
  output logic        flush,
  output logic        timeout_err,
  output logic        busy
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [31:0] perf_issued,
  output logic [31:0] perf_stall
`endif
);
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  alu_seq_state_e         state;
  alu_issue_t             wdata, head, cur, drv;
  logic [CW-1:0]          cnt;
  logic                   full, empty, in_wait;
  logic [$clog2(DEPTH):0] count;

  always_comb begin
    wdata          = '0;
    wdata.op       = issue_op_code;
    wdata.a        = issue_A;
    wdata.b        = issue_B;
    wdata.dest     = issue_dest;
    wdata.reg_addr = issue_reg_addr;
    wdata.mem_addr = issue_mem_addr;
  end

  alu_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (issue_valid && issue_ready),
    .pop   (state == ISSUE),
    .clear (flush),
    .wdata (wdata),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign issue_ready = !full;
  assign busy        = (state != IDLE) || (count != '0);
  assign in_wait     = (state == WAIT_DONE);
  assign flush       = in_wait && alu_done && (cur.dest == DEST_PC);
  assign timeout_err = in_wait && !alu_done && (cnt == CW'(TIMEOUT_CYCLES - 1));

  // Ending an op (done or timeout) goes straight to ISSUE when work is queued.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      cur   <= '0;
    end else begin
      case (state)
        IDLE:      if (!empty) state <= ISSUE;
        ISSUE: begin
          cur   <= head;
          cnt   <= '0;
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          cnt <= cnt + 1'b1;
          if (alu_done)         state <= (flush || empty) ? IDLE : ISSUE;
          else if (timeout_err) state <= empty ? IDLE : ISSUE;
        end
        default:   state <= IDLE;
      endcase
    end
  end

  // Head is live during ISSUE; the latched copy holds the fields stable while waiting.
  always_comb begin
    drv              = '0;
    alu_inputs_valid = 1'b0;
    if (state == ISSUE) begin
      drv              = head;
      alu_inputs_valid = 1'b1;
    end else if (in_wait) begin
      drv = cur;
    end
  end

  assign alu_op_code  = drv.op;
  assign alu_input_A  = drv.a;
  assign alu_input_B  = drv.b;
  assign alu_reg_out  = (state != IDLE) && (drv.dest == DEST_REG);
  assign alu_mem_out  = (state != IDLE) && (drv.dest == DEST_MEM);
  assign alu_pc_jump  = (state != IDLE) && (drv.dest == DEST_PC);
  assign alu_reg_addr = alu_reg_out ? drv.reg_addr : '0;
  assign alu_mem_addr = alu_mem_out ? drv.mem_addr : '0;

`ifdef ALU_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (state == ISSUE)             perf_issued <= perf_issued + 32'd1;
      if (issue_valid && !issue_ready) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: field-mapping vector table plus backpressure, flush, timeout, reset sequences.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic        issue_ready;
  ALU_OP_CODE  issue_op_code;
  logic [31:0] issue_A, issue_B;
  dest_kind_e  issue_dest;
  logic [4:0]  issue_reg_addr;
  logic [31:0] issue_mem_addr;
  ALU_OP_CODE  alu_op_code;
  logic [31:0] alu_input_A, alu_input_B;
  logic        alu_reg_out, alu_mem_out, alu_pc_jump, alu_inputs_valid;
  logic [4:0]  alu_reg_addr;
  logic [31:0] alu_mem_addr;
  logic        alu_done, flush, timeout_err, busy;

  int checks = 0;
  int failures = 0;
  logic [31:0] issued_q[$];

  alu_sequencer #(.DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op_code(issue_op_code), .issue_A(issue_A), .issue_B(issue_B),
    .issue_dest(issue_dest), .issue_reg_addr(issue_reg_addr), .issue_mem_addr(issue_mem_addr),
    .alu_op_code(alu_op_code), .alu_input_A(alu_input_A), .alu_input_B(alu_input_B),
    .alu_reg_out(alu_reg_out), .alu_reg_addr(alu_reg_addr),
    .alu_mem_out(alu_mem_out), .alu_mem_addr(alu_mem_addr),
    .alu_pc_jump(alu_pc_jump), .alu_inputs_valid(alu_inputs_valid),
    .alu_done(alu_done), .flush(flush), .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (alu_inputs_valid) issued_q.push_back(alu_input_A);

  typedef struct {
    ALU_OP_CODE  op;
    logic [31:0] a, b;
    dest_kind_e  dest;
    logic [4:0]  rd;
    logic [31:0] ma;
    logic        e_reg, e_mem, e_pc;
    logic [4:0]  e_rd;
    logic [31:0] e_ma;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task step();
    @(posedge clk);
    #1;
  endtask

  task push_op(input ALU_OP_CODE op, input logic [31:0] a, input logic [31:0] b,
               input dest_kind_e d, input logic [4:0] rd, input logic [31:0] ma);
    issue_op_code = op; issue_A = a; issue_B = b; issue_dest = d;
    issue_reg_addr = rd; issue_mem_addr = ma; issue_valid = 1'b1;
    step();
    issue_valid = 1'b0;
  endtask

  task automatic wait_issue(input string name);
    int n = 0;
    while (!alu_inputs_valid && n < 10) begin
      step();
      n++;
    end
    chk({name, "_issue_seen"}, 32'(alu_inputs_valid), 32'd1);
  endtask

  initial begin
    vecs[0] = '{OP_ADD, 32'd7,  32'd9,  DEST_REG, 5'd3,  32'h55,   1'b1, 1'b0, 1'b0, 5'd3,  32'h0};
    vecs[1] = '{OP_SUB, 32'd40, 32'd2,  DEST_MEM, 5'd17, 32'h1000, 1'b0, 1'b1, 1'b0, 5'd0,  32'h1000};
    vecs[2] = '{OP_XOR, 32'hF0, 32'h0F, DEST_PC,  5'd9,  32'hBEEF, 1'b0, 1'b0, 1'b1, 5'd0,  32'h0};
    vecs[3] = '{OP_SLT, 32'hFFFFFFFF, 32'd1, DEST_REG, 5'd31, 32'h0, 1'b1, 1'b0, 1'b0, 5'd31, 32'h0};

    reset = 1'b1; issue_valid = 1'b0; alu_done = 1'b0;
    issue_op_code = OP_ADD; issue_A = '0; issue_B = '0; issue_dest = DEST_REG;
    issue_reg_addr = '0; issue_mem_addr = '0;

    // 1: reset state
    repeat (3) step();
    chk("rst_valid", 32'(alu_inputs_valid), 0);
    chk("rst_ready", 32'(issue_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_reg_out", 32'(alu_reg_out), 0);
    reset = 1'b0;
    step();

    // 2: single op, done two cycles after issue
    push_op(OP_ADD, 32'd1, 32'd1, DEST_REG, 5'd5, 32'h0);
    chk("t2_idle_busy", 32'(busy), 1);
    chk("t2_idle_valid", 32'(alu_inputs_valid), 0);
    step();
    chk("t2_issue_valid", 32'(alu_inputs_valid), 1);
    chk("t2_issue_reg_out", 32'(alu_reg_out), 1);
    chk("t2_issue_reg_addr", 32'(alu_reg_addr), 5);
    chk("t2_issue_A", alu_input_A, 1);
    step();
    chk("t2_wait_valid", 32'(alu_inputs_valid), 0);
    chk("t2_wait_reg_addr", 32'(alu_reg_addr), 5);
    chk("t2_wait_B", alu_input_B, 1);
    step();
    alu_done = 1'b1;
    #1;
    chk("t2_done_held", 32'(alu_reg_out), 1);
    chk("t2_done_flush", 32'(flush), 0);
    step();
    alu_done = 1'b0;
    chk("t2_after_busy", 32'(busy), 0);
    chk("t2_after_reg_out", 32'(alu_reg_out), 0);
    chk("t2_after_valid", 32'(alu_inputs_valid), 0);

    // field-mapping table
    for (int i = 0; i < 4; i++) begin
      push_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dest, vecs[i].rd, vecs[i].ma);
      wait_issue($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_op", i), 32'(alu_op_code), 32'(vecs[i].op));
      chk($sformatf("vec%0d_A", i), alu_input_A, vecs[i].a);
      chk($sformatf("vec%0d_B", i), alu_input_B, vecs[i].b);
      chk($sformatf("vec%0d_reg_out", i), 32'(alu_reg_out), 32'(vecs[i].e_reg));
      chk($sformatf("vec%0d_mem_out", i), 32'(alu_mem_out), 32'(vecs[i].e_mem));
      chk($sformatf("vec%0d_pc_jump", i), 32'(alu_pc_jump), 32'(vecs[i].e_pc));
      chk($sformatf("vec%0d_reg_addr", i), 32'(alu_reg_addr), 32'(vecs[i].e_rd));
      chk($sformatf("vec%0d_mem_addr", i), alu_mem_addr, vecs[i].e_ma);
      step();
      alu_done = 1'b1;
      #1;
      chk($sformatf("vec%0d_flush", i), 32'(flush), 32'(vecs[i].e_pc));
      chk($sformatf("vec%0d_held_mem_addr", i), alu_mem_addr, vecs[i].e_ma);
      step();
      alu_done = 1'b0;
      chk($sformatf("vec%0d_idle_busy", i), 32'(busy), 0);
    end

    // 3: backpressure with done withheld, then in-order drain
    issued_q.delete();
    for (int k = 1; k <= 5; k++) begin
      push_op(OP_ADD, 32'(k), 32'd0, DEST_REG, 5'd1, 32'h0);
      if (k == 4) chk("t3_ready_before_full", 32'(issue_ready), 1);
    end
    chk("t3_ready_full", 32'(issue_ready), 0);
    chk("t3_busy_full", 32'(busy), 1);
    alu_done = 1'b1;
    step();
    alu_done = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      wait_issue($sformatf("t3_op%0d", k));
      step();
      alu_done = 1'b1;
      step();
      alu_done = 1'b0;
    end
    chk("t3_drained_busy", 32'(busy), 0);
    chk("t3_issue_count", 32'(issued_q.size()), 5);
    for (int k = 0; k < 5; k++)
      chk($sformatf("t3_order%0d", k), (k < issued_q.size()) ? issued_q[k] : 32'hDEAD, 32'(k + 1));

    // 4: flush on PC op discards queued ops and a same-cycle push
    issued_q.delete();
    push_op(OP_ADD, 32'd10, 32'd0, DEST_PC, 5'd0, 32'h0);
    push_op(OP_ADD, 32'd11, 32'd0, DEST_REG, 5'd2, 32'h0);
    push_op(OP_ADD, 32'd12, 32'd0, DEST_REG, 5'd3, 32'h0);
    issue_A = 32'd13; issue_dest = DEST_REG; issue_valid = 1'b1;
    alu_done = 1'b1;
    #1;
    chk("t4_flush_pulse", 32'(flush), 1);
    step();
    alu_done = 1'b0; issue_valid = 1'b0;
    chk("t4_flush_drop", 32'(flush), 0);
    chk("t4_busy_after_flush", 32'(busy), 0);
    repeat (5) step();
    chk("t4_issue_count", 32'(issued_q.size()), 1);
    chk("t4_only_pc_op", (issued_q.size() > 0) ? issued_q[0] : 32'hDEAD, 32'd10);

    // 5: timeout after 8 cycles, next op issues immediately; done on the limit cycle wins
    push_op(OP_ADD, 32'd20, 32'd0, DEST_REG, 5'd4, 32'h0);
    push_op(OP_ADD, 32'd21, 32'd0, DEST_REG, 5'd4, 32'h0);
    chk("t5_issue20", alu_input_A, 20);
    repeat (7) step();
    chk("t5_no_early_timeout", 32'(timeout_err), 0);
    step();
    chk("t5_timeout_pulse", 32'(timeout_err), 1);
    chk("t5_timeout_valid", 32'(alu_inputs_valid), 0);
    step();
    chk("t5_timeout_clear", 32'(timeout_err), 0);
    chk("t5_next_valid", 32'(alu_inputs_valid), 1);
    chk("t5_next_A", alu_input_A, 21);
    repeat (8) step();
    alu_done = 1'b1;
    #1;
    chk("t5_done_wins", 32'(timeout_err), 0);
    step();
    alu_done = 1'b0;
    chk("t5_idle_busy", 32'(busy), 0);

    // 6: reset in WAIT_DONE with 3 queued
    for (int k = 0; k < 4; k++) push_op(OP_OR, 32'(30 + k), 32'd1, DEST_MEM, 5'd0, 32'h40);
    chk("t6_wait_mem_out", 32'(alu_mem_out), 1);
    chk("t6_queue_full_ready", 32'(issue_ready), 1);
    reset = 1'b1;
    step();
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_mem_out", 32'(alu_mem_out), 0);
    chk("t6_rst_mem_addr", alu_mem_addr, 0);
    chk("t6_rst_A", alu_input_A, 0);
    chk("t6_rst_valid", 32'(alu_inputs_valid), 0);
    reset = 1'b0;
    repeat (3) step();
    chk("t6_stays_idle", 32'(busy), 0);
    chk("t6_no_issue", 32'(alu_inputs_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
